// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
//   in_valid/in_ready   : operation request handshake carrying x, y and sub
//   out_valid/out_ready : result handshake carrying s and the c_out/ovf/zero/neg flags
// master: the requester (drives operands, consumes the result)
// slave : the adder/subtractor
interface addsub_serial_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c_out;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, x, y, sub, out_ready,
      input  in_ready, out_valid, s, c_out, ovf, zero, neg
   );

   modport slave (
      input  in_valid, x, y, sub, out_ready,
      output in_ready, out_valid, s, c_out, ovf, zero, neg
   );
endinterface

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor. Accepts x, y and sub on the input handshake, then
// adds DIGIT bits per clock (LSB digit first) through a single DIGIT-bit carry chain,
// and presents s with carry/borrow, signed overflow, zero and negative flags on the
// output handshake. WIDTH must be an exact multiple of DIGIT.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : addsub_serial_if slave (in_valid/in_ready/x/y/sub, out_valid/out_ready/
//           s/c_out/ovf/zero/neg)
module addsub_serial #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input logic            clk,
   input logic            rst_n,
   addsub_serial_if.slave bus
);
   localparam int unsigned NSTEP = WIDTH / DIGIT;
   localparam int unsigned STEPW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             carry_q;
   logic             sub_q;
   logic [STEPW-1:0] step_q;
   logic             c_out_q;
   logic             ovf_q;
   logic             zero_q;
   logic             neg_q;

   logic [DIGIT-1:0] a_dig;
   logic [DIGIT-1:0] b_dig;
   logic [DIGIT-1:0] sum_dig;
   logic             carry_nxt;
   logic             carry_msb;
   logic [WIDTH-1:0] s_nxt;
   logic             last_step;

   // Digit select and result merge use constant slices per step value so the mux
   // stays a plain decode of step_q.
   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < int'(NSTEP); i++) begin
         if (step_q == STEPW'(i)) begin
            a_dig = a_q[i*DIGIT +: DIGIT];
            b_dig = b_q[i*DIGIT +: DIGIT];
         end
      end
      {carry_nxt, sum_dig} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
      s_nxt = s_q;
      for (int i = 0; i < int'(NSTEP); i++) begin
         if (step_q == STEPW'(i)) begin
            s_nxt[i*DIGIT +: DIGIT] = sum_dig;
         end
      end
      // Only meaningful on the last step: sum bit = a ^ b ^ cin, so cin recovers from it.
      carry_msb = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_dig[DIGIT-1];
   end

   assign last_step = (step_q == STEPW'(NSTEP - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         sub_q   <= 1'b0;
         step_q  <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  // Subtraction as x + ~y + 1: invert B and seed the carry.
                  a_q     <= bus.x;
                  b_q     <= bus.y ^ {WIDTH{bus.sub}};
                  carry_q <= bus.sub;
                  sub_q   <= bus.sub;
                  step_q  <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               s_q     <= s_nxt;
               carry_q <= carry_nxt;
               step_q  <= step_q + STEPW'(1);
               if (last_step) begin
                  c_out_q <= carry_nxt ^ sub_q;
                  ovf_q   <= carry_msb ^ carry_nxt;
                  zero_q  <= (s_nxt == '0);
                  neg_q   <= s_nxt[WIDTH-1];
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.s         = s_q;
   assign bus.c_out     = c_out_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
Parametrised, digit-serial adder/subtractor that succeeds the fixed 4-bit ripple add/sub. It accepts two WIDTH-bit operands and a mode bit through a valid/ready handshake. It computes DIGIT bits per clock, LSB digit first, reusing one DIGIT-bit carry chain across the cycles. It returns the sum or difference with carry/borrow, signed overflow, zero and negative flags through a second valid/ready handshake. It sits between operand registers and the datapath result bus in the small-ALU path.

Parameters:
WIDTH, 16, operand/result width in bits; must be an exact multiple of DIGIT.
DIGIT, 4, bits processed per clock; NSTEP = WIDTH/DIGIT digit cycles per operation.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept an operation.
x  input  WIDTH  operand A.
y  input  WIDTH  operand B.
sub  input  1  0 = x+y, 1 = x-y.
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer accepts the result.
s  output  WIDTH  result, modulo 2^WIDTH.
c_out  output  1  add: carry out; sub: borrow (raw carry XOR sub).
ovf  output  1  signed two's-complement overflow.
zero  output  1  s == 0.
neg  output  1  s[WIDTH-1].

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE, in_ready=1, out_valid=0; s, c_out, ovf, zero, neg all 0; step counter 0. Reset overrides any handshake in the same cycle. Reset during RUN or DONE discards the operation without producing a result.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid at an edge → latch x, B = y XOR {WIDTH{sub}}, carry = sub, sub flag; step=0; go RUN.
- RUN: in_ready=0, out_valid=0.
  - Each edge adds digit [step*DIGIT +: DIGIT] of A and B plus carry.
  - Writes the digit into the result register, updates carry, and increments step.
  - On the edge that processes step NSTEP-1: capture the final carry and the carry into the MSB, then go DONE.
- DONE: out_valid=1 and outputs stable.
  - out_ready at an edge → IDLE, out_valid=0 on the next cycle.
  - Without out_ready, hold DONE and all outputs indefinitely.
- Latency: out_valid rises exactly NSTEP edges after the accepting edge.
- Throughput: one operation per NSTEP+2 cycles minimum. No overlap; in_ready is 0 in RUN and DONE.
- Inputs x, y and sub are ignored outside the accepting edge; changing them mid-operation has no effect.
- Flags are derived from the final values:
  - c_out = carry_out XOR sub.
  - ovf = carry_into_MSB XOR carry_out.
  - zero = (s == 0).
  - neg = s[WIDTH-1].
- s holds partial digits during RUN. Consumers sample s only when out_valid=1.
- Degenerate case WIDTH == DIGIT (NSTEP=1): RUN lasts one cycle and behaviour is otherwise identical.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Add, WIDTH=16, DIGIT=4, sub=0, x=0x1234, y=0x0FCD → s=0x2201, c_out=0, ovf=0, zero=0, neg=0; out_valid exactly 4 edges after acceptance.
- Subtract with borrow, x=0x0003, y=0x0005, sub=1 → s=0xFFFE, c_out=1, ovf=0, neg=1, zero=0.
- Signed overflow:
  - add x=0x7FFF, y=0x0001 → s=0x8000, ovf=1, c_out=0, neg=1.
  - sub x=0x8000, y=0x0001 → s=0x7FFF, ovf=1, c_out=0.
- Zero and backpressure: sub x=0x5555, y=0x5555 → s=0x0000, zero=1, c_out=0. Hold out_ready=0 for 10 cycles → out_valid and all outputs held stable, in_ready=0. Then raise out_ready → next cycle out_valid=0, in_ready=1.
- Reset mid-operation: accept x=0xFFFF, y=0x0001, assert rst_n=0 at step 2 → next cycle all outputs 0, in_ready=1. New op x=0x0001, y=0x0001 add → s=0x0002 with normal 4-cycle latency.
- Input change during RUN plus back-to-back: alter x, y and sub each RUN cycle → result matches the latched operands. Hold in_valid high continuously → exactly one acceptance per IDLE visit, no dropped or duplicated results.
